// File: rtl/vram_blit_ctrl.sv
// Port-A sequencer for the menu nametable/attribute RAM: runs FILL/COPY block
// commands and lets CPU register accesses take the port whenever they request it.
module vram_blit_ctrl #(
   parameter int AW = 11,
   parameter int LW = 12
) (
   input  logic          clk,
   input  logic          sys_rst,
   input  logic          cmd_start,
   input  logic [1:0]    cmd_op,
   input  logic [AW-1:0] cmd_src,
   input  logic [AW-1:0] cmd_dst,
   input  logic [LW-1:0] cmd_len,
   input  logic [7:0]    cmd_fill,
   input  logic [3:0]    cmd_atr,
   input  logic          cmd_abort,
   output logic          busy,
   output logic          done,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [7:0]    cpu_di,
   input  logic [3:0]    cpu_atr,
   output logic          cpu_ack,
   output logic [7:0]    cpu_do,
   output logic [AW-1:0] ram_addr,
   output logic          ram_we,
   output logic [7:0]    ram_di,
   output logic [3:0]    ram_atr,
   input  logic [7:0]    ram_do,
   input  logic [3:0]    ram_atr_do
);

   typedef enum logic [1:0] {IDLE, FILL, CP_RD, CP_WR} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] src_q, dst_q;
   logic [LW-1:0] len_q;
   logic [7:0]    fill_q, dbuf_q, cpu_do_q;
   logic [3:0]    atr_q, abuf_q;
   logic          rd_pend_q, dvalid_q, cpu_rd_q, done_q;

   logic          grant, latch, adv_src, adv_dst, eng_we, eng_rd, done_d;
   logic [AW-1:0] eng_addr;
   logic [7:0]    eng_di;
   logic [3:0]    eng_atr;

   assign grant = ~cpu_req;

   always_comb begin
      state_d  = state_q;
      latch    = 1'b0;
      adv_src  = 1'b0;
      adv_dst  = 1'b0;
      eng_we   = 1'b0;
      eng_rd   = 1'b0;
      done_d   = 1'b0;
      eng_addr = dst_q;
      eng_di   = fill_q;
      eng_atr  = atr_q;
      case (state_q)
         IDLE: begin
            if (cmd_start) begin
               latch = 1'b1;
               if (cmd_len == '0 || cmd_op[1])
                  done_d = 1'b1;
               else
                  state_d = cmd_op[0] ? CP_RD : FILL;
            end
         end
         FILL: begin
            if (grant) begin
               eng_we  = 1'b1;
               adv_dst = 1'b1;
               if (len_q == LW'(1)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         CP_RD: begin
            eng_addr = src_q;
            if (grant) begin
               eng_rd  = 1'b1;
               adv_src = 1'b1;
               state_d = CP_WR;
            end
         end
         CP_WR: begin
            // Write straight from the RAM output when the read landed last cycle,
            // otherwise from the buffer filled while the CPU held the port.
            eng_di  = rd_pend_q ? ram_do     : dbuf_q;
            eng_atr = rd_pend_q ? ram_atr_do : abuf_q;
            if (grant && (rd_pend_q || dvalid_q)) begin
               eng_we  = 1'b1;
               adv_dst = 1'b1;
               if (len_q == LW'(1)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = CP_RD;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (cmd_abort && state_q != IDLE) begin
         state_d = IDLE;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (sys_rst) begin
         state_q   <= IDLE;
         src_q     <= '0;
         dst_q     <= '0;
         len_q     <= '0;
         fill_q    <= '0;
         atr_q     <= '0;
         dbuf_q    <= '0;
         abuf_q    <= '0;
         rd_pend_q <= 1'b0;
         dvalid_q  <= 1'b0;
         cpu_rd_q  <= 1'b0;
         cpu_do_q  <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         done_q    <= done_d;
         rd_pend_q <= eng_rd;
         cpu_rd_q  <= cpu_req & ~cpu_we;
         if (cpu_rd_q)
            cpu_do_q <= ram_do;
         if (latch) begin
            src_q  <= cmd_src;
            dst_q  <= cmd_dst;
            len_q  <= cmd_len;
            fill_q <= cmd_fill;
            atr_q  <= cmd_atr;
         end else begin
            if (adv_src)
               src_q <= src_q + 1'b1;
            if (adv_dst) begin
               dst_q <= dst_q + 1'b1;
               if (len_q != '0)
                  len_q <= len_q - 1'b1;
            end
         end
         if (rd_pend_q) begin
            dbuf_q   <= ram_do;
            abuf_q   <= ram_atr_do;
            dvalid_q <= ~eng_we;
         end else if (latch || eng_we) begin
            dvalid_q <= 1'b0;
         end
      end
   end

   assign busy     = (state_q != IDLE);
   assign done     = done_q;
   assign cpu_ack  = cpu_req;
   assign cpu_do   = cpu_do_q;
   assign ram_addr = cpu_req ? cpu_addr : eng_addr;
   assign ram_we   = cpu_req ? cpu_we   : (eng_we & ~sys_rst);
   assign ram_di   = cpu_req ? cpu_di   : eng_di;
   assign ram_atr  = cpu_req ? cpu_atr  : eng_atr;

endmodule

// File: tb/tb_vram_blit_ctrl.sv
// Bench for vram_blit_ctrl: behavioural RAM on port A plus a byte-array reference
// model of the block commands; inputs driven and outputs sampled on the falling edge.
module tb_vram_blit_ctrl;
   localparam int AW = 11;
   localparam int LW = 12;
   localparam int N  = 2048;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          sys_rst, cmd_start, cmd_abort, busy, done;
   logic [1:0]    cmd_op;
   logic [AW-1:0] cmd_src, cmd_dst, cpu_addr, ram_addr;
   logic [LW-1:0] cmd_len;
   logic [7:0]    cmd_fill, cpu_di, cpu_do, ram_di, ram_do;
   logic [3:0]    cmd_atr, cpu_atr, ram_atr, ram_atr_do;
   logic          cpu_req, cpu_we, cpu_ack, ram_we;

   vram_blit_ctrl #(.AW(AW), .LW(LW)) dut (
      .clk(clk), .sys_rst(sys_rst), .cmd_start(cmd_start), .cmd_op(cmd_op),
      .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_fill(cmd_fill),
      .cmd_atr(cmd_atr), .cmd_abort(cmd_abort), .busy(busy), .done(done),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_di(cpu_di),
      .cpu_atr(cpu_atr), .cpu_ack(cpu_ack), .cpu_do(cpu_do), .ram_addr(ram_addr),
      .ram_we(ram_we), .ram_di(ram_di), .ram_atr(ram_atr), .ram_do(ram_do),
      .ram_atr_do(ram_atr_do)
   );

   logic [7:0] ram_ntb [N];
   logic [3:0] ram_at  [N];
   logic [7:0] ref_ntb [N];
   logic [3:0] ref_at  [N];
   logic       load_mem;
   int         wr_cnt;
   int         errors = 0;
   int         checks = 0;

   always @(posedge clk) begin
      if (load_mem) begin
         for (int i = 0; i < N; i++) begin
            ram_ntb[i] <= ref_ntb[i];
            ram_at[i]  <= ref_at[i];
         end
      end else begin
         if (ram_we) begin
            ram_ntb[ram_addr] <= ram_di;
            ram_at[ram_addr]  <= ram_atr;
            wr_cnt <= wr_cnt + 1;
         end
         ram_do     <= ram_ntb[ram_addr];
         ram_atr_do <= ram_at[ram_addr];
      end
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   function automatic void m_fill(input int dst, input int len, input logic [7:0] f, input logic [3:0] a);
      for (int i = 0; i < len; i++) begin
         ref_ntb[(dst + i) % N] = f;
         ref_at[(dst + i) % N]  = a;
      end
   endfunction

   // Ascending byte-by-byte copy; overlapping forward copies replicate naturally.
   function automatic void m_copy(input int src, input int dst, input int len);
      for (int i = 0; i < len; i++) begin
         ref_ntb[(dst + i) % N] = ref_ntb[(src + i) % N];
         ref_at[(dst + i) % N]  = ref_at[(src + i) % N];
      end
   endfunction

   function automatic int mem_diff();
      int n = 0;
      for (int i = 0; i < N; i++)
         if (ram_ntb[i] !== ref_ntb[i] || ram_at[i] !== ref_at[i]) n++;
      return n;
   endfunction

   task automatic issue(input logic [1:0] op, input int src, input int dst, input int len,
                        input logic [7:0] f, input logic [3:0] a);
      logic [31:0] s, d, l;
      s = src; d = dst; l = len;
      cmd_op = op; cmd_src = s[AW-1:0]; cmd_dst = d[AW-1:0]; cmd_len = l[LW-1:0];
      cmd_fill = f; cmd_atr = a; cmd_start = 1'b1;
      cyc();
      cmd_start = 1'b0;
   endtask

   task automatic wait_done(input int c0, input int budget, output int c);
      c = c0;
      while (done !== 1'b1) begin
         if (c >= budget) begin
            c = -1;
            return;
         end
         cyc();
         c++;
      end
   endtask

   task automatic test_reset();
      sys_rst = 1'b1;
      repeat (3) cyc();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we: got %b expected 0", ram_we); end
      checks++; if (ram_addr !== '0) begin errors++; $display("FAIL reset_ram_addr: got %h expected 000", ram_addr); end
      checks++; if (cpu_do !== '0) begin errors++; $display("FAIL reset_cpu_do: got %h expected 00", cpu_do); end
      sys_rst = 1'b0;
      cyc();
   endtask

   task automatic test_fill_wrap();
      int c, w0;
      w0 = wr_cnt;
      issue(2'd0, 0, 'h7F8, 16, 8'h20, 4'h5);
      m_fill('h7F8, 16, 8'h20, 4'h5);
      wait_done(1, 200, c);
      checks++; if (c !== 17) begin errors++; $display("FAIL fill_wrap_done_cycle: got %0d expected 17", c); end
      checks++; if (wr_cnt - w0 !== 16) begin errors++; $display("FAIL fill_wrap_writes: got %0d expected 16", wr_cnt - w0); end
      checks++; if (mem_diff() !== 0) begin errors++; $display("FAIL fill_wrap_mem: %0d bytes differ, expected 0", mem_diff()); end
      checks++; if (ram_ntb['h000] !== 8'h20 || ram_at['h007] !== 4'h5) begin
         errors++; $display("FAIL fill_wrap_low: got %h/%h expected 20/5", ram_ntb['h000], ram_at['h007]); end
      cyc();
   endtask

   task automatic test_copy_basic();
      int c, w0, busy_bad;
      w0 = wr_cnt; busy_bad = 0;
      issue(2'd1, 'h100, 'h400, 32, 8'h00, 4'h0);
      m_copy('h100, 'h400, 32);
      c = 1;
      while (done !== 1'b1 && c < 300) begin
         if (busy !== 1'b1) busy_bad++;
         cyc();
         c++;
      end
      checks++; if (c !== 65) begin errors++; $display("FAIL copy_done_cycle: got %0d expected 65", c); end
      checks++; if (busy_bad !== 0) begin errors++; $display("FAIL copy_busy: %0d low cycles, expected 0", busy_bad); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL copy_busy_at_done: got %b expected 0", busy); end
      checks++; if (wr_cnt - w0 !== 32) begin errors++; $display("FAIL copy_writes: got %0d expected 32", wr_cnt - w0); end
      checks++; if (mem_diff() !== 0) begin errors++; $display("FAIL copy_mem: %0d bytes differ, expected 0", mem_diff()); end
      cyc();
   endtask

   task automatic test_cpu_steal();
      int c, dc, chk_c, w0, dst, exp_c, g, rd_n, rd_bad;
      logic [7:0] f;
      dst = $urandom_range('h100, 'h600);
      f = 8'($urandom);
      w0 = wr_cnt; dc = -1; chk_c = -1; rd_n = 0; rd_bad = 0;
      issue(2'd0, 0, dst, 64, f, 4'hA);
      m_fill(dst, 64, f, 4'hA);
      g = 0; exp_c = 0;
      for (int e = 1; e < 1000 && exp_c == 0; e++)
         if (e % 3 != 0) begin g++; if (g == 64) exp_c = e + 1; end
      for (c = 1; c < 400; c++) begin
         if (c == chk_c) begin
            rd_n++;
            if (cpu_do !== ref_ntb['h010]) begin
               rd_bad++; $display("FAIL steal_cpu_read: got %h expected %h", cpu_do, ref_ntb['h010]); end
         end
         if (done === 1'b1 && dc < 0) dc = c;
         if (dc >= 0 && c > chk_c) break;
         cpu_req = (dc < 0 && c % 3 == 0);
         cpu_we = 1'b0; cpu_addr = 'h010;
         if (cpu_req) chk_c = c + 2;
         cyc();
      end
      cpu_req = 1'b0;
      checks++; if (dc !== exp_c) begin errors++; $display("FAIL steal_done_cycle: got %0d expected %0d", dc, exp_c); end
      checks++; if (wr_cnt - w0 !== 64) begin errors++; $display("FAIL steal_writes: got %0d expected 64", wr_cnt - w0); end
      checks++; if (rd_bad !== 0 || rd_n < 20) begin errors++; $display("FAIL steal_reads: %0d bad of %0d, expected 0 bad", rd_bad, rd_n); end
      checks++; if (mem_diff() !== 0) begin errors++; $display("FAIL steal_mem: %0d bytes differ, expected 0", mem_diff()); end
   endtask

   task automatic test_copy_cpu_write();
      int c, w0;
      logic [7:0] x;
      w0 = wr_cnt;
      x = ~ref_ntb['h200];
      issue(2'd1, 'h200, 'h300, 4, 8'h00, 4'h0);
      cyc();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 'h300; cpu_di = x; cpu_atr = 4'hC;
      #1;
      checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL cw_ack: got %b expected 1", cpu_ack); end
      cyc();
      cpu_req = 1'b0; cpu_we = 1'b0;
      ref_ntb['h300] = x; ref_at['h300] = 4'hC;
      m_copy('h200, 'h300, 4);
      wait_done(3, 200, c);
      checks++; if (c !== 10) begin errors++; $display("FAIL cw_done_cycle: got %0d expected 10", c); end
      checks++; if (ram_ntb['h300] !== ref_ntb['h200]) begin
         errors++; $display("FAIL cw_overwrite: got %h expected %h", ram_ntb['h300], ref_ntb['h200]); end
      checks++; if (wr_cnt - w0 !== 5) begin errors++; $display("FAIL cw_writes: got %0d expected 5", wr_cnt - w0); end
      checks++; if (mem_diff() !== 0) begin errors++; $display("FAIL cw_mem: %0d bytes differ, expected 0", mem_diff()); end
      cyc();
   endtask

   task automatic test_noop();
      int w0;
      logic [1:0] ops [2];
      int lens [2];
      ops[0] = 2'd0; lens[0] = 0;
      ops[1] = 2'd2; lens[1] = 5;
      for (int k = 0; k < 2; k++) begin
         w0 = wr_cnt;
         issue(ops[k], 'h50, 'h60, lens[k], 8'hEE, 4'h1);
         checks++; if (done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL noop%0d_done: got done=%b busy=%b expected 1/0", k, done, busy); end
         cyc();
         checks++; if (done !== 1'b0) begin errors++; $display("FAIL noop%0d_pulse: got %b expected 0", k, done); end
         checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL noop%0d_writes: got %0d expected 0", k, wr_cnt - w0); end
      end
   endtask

   // mode 0: abort, engine granted; 1: abort with CPU read that cycle; 2: sys_rst
   task automatic test_abort(input int mode);
      int w0, dst, exp_w, done_seen;
      dst = $urandom_range('h080, 'h0F0);
      exp_w = (mode == 0) ? 6 : 5;
      w0 = wr_cnt; done_seen = 0;
      issue(2'd0, 0, dst, 20, 8'h5A, 4'h3);
      repeat (5) cyc();
      if (mode == 2) sys_rst = 1'b1;
      else cmd_abort = 1'b1;
      if (mode == 1) begin cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 'h010; end
      cyc();
      sys_rst = 1'b0; cmd_abort = 1'b0; cpu_req = 1'b0;
      m_fill(dst, exp_w, 8'h5A, 4'h3);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort%0d_busy: got %b expected 0", mode, busy); end
      for (int i = 0; i < 6; i++) begin
         if (done === 1'b1) done_seen++;
         cyc();
      end
      checks++; if (done_seen !== 0) begin errors++; $display("FAIL abort%0d_done: %0d pulses expected 0", mode, done_seen); end
      checks++; if (wr_cnt - w0 !== exp_w) begin errors++; $display("FAIL abort%0d_writes: got %0d expected %0d", mode, wr_cnt - w0, exp_w); end
      checks++; if (mem_diff() !== 0) begin errors++; $display("FAIL abort%0d_mem: %0d bytes differ, expected 0", mode, mem_diff()); end
      if (mode == 2) begin
         checks++; if (ram_addr !== '0) begin errors++; $display("FAIL rst_mid_addr: got %h expected 000", ram_addr); end
      end
   endtask

   task automatic test_back_to_back();
      int c;
      issue(2'd0, 0, 'h500, 3, 8'h11, 4'h7);
      m_fill('h500, 3, 8'h11, 4'h7);
      wait_done(1, 100, c);
      checks++; if (c !== 4) begin errors++; $display("FAIL b2b_first_done: got %0d expected 4", c); end
      issue(2'd1, 'h500, 'h510, 2, 8'h00, 4'h0);
      m_copy('h500, 'h510, 2);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy=%b expected 1", busy); end
      wait_done(1, 100, c);
      checks++; if (c !== 5) begin errors++; $display("FAIL b2b_second_done: got %0d expected 5", c); end
      checks++; if (mem_diff() !== 0) begin errors++; $display("FAIL b2b_mem: %0d bytes differ, expected 0", mem_diff()); end
      cyc();
   endtask

   task automatic test_overlap();
      int c;
      issue(2'd1, 'h7FC, 'h7FD, 8, 8'h00, 4'h0);
      m_copy('h7FC, 'h7FD, 8);
      wait_done(1, 100, c);
      checks++; if (c !== 17) begin errors++; $display("FAIL overlap_done: got %0d expected 17", c); end
      checks++; if (ram_ntb['h004] !== ref_ntb['h7FC]) begin
         errors++; $display("FAIL overlap_replicate: got %h expected %h", ram_ntb['h004], ref_ntb['h7FC]); end
      checks++; if (mem_diff() !== 0) begin errors++; $display("FAIL overlap_mem: %0d bytes differ, expected 0", mem_diff()); end
      cyc();
   endtask

   task automatic test_random();
      int c, src, dst, len, exp_c;
      logic [1:0] op;
      logic [7:0] f;
      logic [3:0] a;
      for (int k = 0; k < 8; k++) begin
         op = 2'($urandom_range(0, 1));
         src = $urandom_range(0, N - 1);
         dst = $urandom_range(0, N - 1);
         len = $urandom_range(1, 40);
         f = 8'($urandom); a = 4'($urandom);
         issue(op, src, dst, len, f, a);
         if (op == 2'd0) begin m_fill(dst, len, f, a); exp_c = len + 1; end
         else begin m_copy(src, dst, len); exp_c = 2 * len + 1; end
         wait_done(1, 200, c);
         checks++; if (c !== exp_c) begin errors++; $display("FAIL rand%0d_done: got %0d expected %0d", k, c, exp_c); end
         checks++; if (mem_diff() !== 0) begin errors++; $display("FAIL rand%0d_mem: %0d bytes differ, expected 0", k, mem_diff()); end
         cyc();
      end
   endtask

   initial begin
      sys_rst = 1'b1; cmd_start = 1'b0; cmd_abort = 1'b0; cmd_op = '0;
      cmd_src = '0; cmd_dst = '0; cmd_len = '0; cmd_fill = '0; cmd_atr = '0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_di = '0; cpu_atr = '0;
      for (int i = 0; i < N; i++) begin
         ref_ntb[i] = 8'($urandom);
         ref_at[i]  = 4'($urandom);
      end
      load_mem = 1'b1;
      cyc();
      load_mem = 1'b0;
      test_reset();
      test_fill_wrap();
      test_copy_basic();
      test_cpu_steal();
      test_copy_cpu_write();
      test_noop();
      test_abort(0);
      test_abort(1);
      test_abort(2);
      test_back_to_back();
      test_overlap();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
